// File: rtl/param_mem_responder.sv
// Word-addressed memory responder with fixed request-to-response latency,
// byte-enabled writes, per-request error detection and sticky error flags.
module param_mem_responder #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DEPTH     = 256,
    parameter int unsigned LATENCY   = 2,
    parameter logic [31:0] INIT_WORD = 32'h00000013
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                mem_read,
    input  logic                mem_write,
    input  logic [DATA_W/8-1:0] mem_byte_enable,
    input  logic [ADDR_W-1:0]   mem_address,
    input  logic [DATA_W-1:0]   mem_wdata,
    input  logic                halt,
    output logic                mem_resp,
    output logic [DATA_W-1:0]   mem_rdata,
    output logic                mem_error,
    output logic [15:0]         errcode,
    output logic                busy
);

    localparam int unsigned BYTES     = DATA_W / 8;
    localparam int unsigned OFF       = $clog2(BYTES);
    localparam int unsigned IDX_W     = $clog2(DEPTH);
    localparam int unsigned CNT_W     = $clog2(LATENCY + 1);
    localparam int unsigned MEM_BYTES = DEPTH * BYTES;
    localparam int unsigned CMP_W     = ADDR_W + 32;
    localparam logic [DATA_W-1:0] INIT_VAL = DATA_W'(INIT_WORD);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [BYTES-1:0]    be_q, be_d;
    logic                is_read_q, is_read_d;
    logic                is_write_q, is_write_d;
    logic                req_err_q, req_err_d;
    logic                resp_q, resp_d;
    logic                err_q, err_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [15:0]         errcode_q, errcode_d;
    logic                busy_q, busy_d;

    logic [DATA_W-1:0]   mem_q [DEPTH];
    logic [DATA_W-1:0]   be_mask_c;
    logic [DATA_W-1:0]   wr_word_c;
    logic                wr_en_c;
    logic                accept_c;
    logic [15:0]         new_err_c;

    // Expand byte enables into a bit mask for the read-modify-write merge.
    for (genvar g = 0; g < BYTES; g++) begin : g_be_mask
        assign be_mask_c[g*8 +: 8] = {8{be_q[g]}};
    end

    assign wr_word_c = (mem_q[idx_q] & ~be_mask_c) | (wdata_q & be_mask_c);
    assign accept_c  = (state_q == IDLE) && !halt && (mem_read || mem_write);

    // Error classification of the request currently on the bus.
    always_comb begin
        new_err_c    = '0;
        new_err_c[0] = mem_read && mem_write;
        new_err_c[1] = (mem_address & ADDR_W'(BYTES - 1)) != '0;
        new_err_c[2] = CMP_W'(mem_address) >= CMP_W'(MEM_BYTES);
        new_err_c[4] = mem_write && (mem_byte_enable == '0);
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        is_read_d  = is_read_q;
        is_write_d = is_write_q;
        req_err_d  = req_err_q;
        errcode_d  = errcode_q;
        rdata_d    = rdata_q;
        resp_d     = 1'b0;
        err_d      = 1'b0;
        busy_d     = 1'b0;
        wr_en_c    = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept_c) begin
                    idx_d      = mem_address[OFF+IDX_W-1:OFF];
                    wdata_d    = mem_wdata;
                    be_d       = mem_byte_enable;
                    is_read_d  = mem_read;
                    is_write_d = mem_write;
                    req_err_d  = |new_err_c;
                    errcode_d  = errcode_q | new_err_c;
                    if (LATENCY == 1) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_W'(LATENCY - 1);
                    end
                end
            end
            WAIT: begin
                // A requester letting go mid-flight is only recorded, not failed.
                if (!mem_read && !mem_write) begin
                    errcode_d[3] = 1'b1;
                end
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = RESP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
                wr_en_c = is_write_q && !req_err_q;
            end
            default: state_d = IDLE;
        endcase

        if (state_d == RESP) begin
            resp_d = 1'b1;
            err_d  = req_err_d;
            if (req_err_d) begin
                rdata_d = '0;
            end else if (is_read_d) begin
                rdata_d = mem_q[idx_d];
            end
        end
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            wdata_q    <= '0;
            be_q       <= '0;
            is_read_q  <= 1'b0;
            is_write_q <= 1'b0;
            req_err_q  <= 1'b0;
            resp_q     <= 1'b0;
            err_q      <= 1'b0;
            rdata_q    <= '0;
            errcode_q  <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            wdata_q    <= wdata_d;
            be_q       <= be_d;
            is_read_q  <= is_read_d;
            is_write_q <= is_write_d;
            req_err_q  <= req_err_d;
            resp_q     <= resp_d;
            err_q      <= err_d;
            rdata_q    <= rdata_d;
            errcode_q  <= errcode_d;
            busy_q     <= busy_d;
        end
    end

    // Storage array; every word returns to INIT_WORD on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[IDX_W'(i)] <= INIT_VAL;
            end
        end else if (wr_en_c) begin
            mem_q[idx_q] <= wr_word_c;
        end
    end

    assign mem_resp  = resp_q;
    assign mem_error = err_q;
    assign mem_rdata = rdata_q;
    assign errcode   = errcode_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_param_mem_responder.sv
// Bench for param_mem_responder: directed scenarios plus randomized traffic on
// LATENCY=2 and LATENCY=1 instances, checked against a byte-addressed model.
module tb_param_mem_responder;

    logic        clk;
    logic        rst_n;
    logic        rd   [2];
    logic        wr   [2];
    logic        hl   [2];
    logic [3:0]  be   [2];
    logic [31:0] ad   [2];
    logic [31:0] wd   [2];
    logic        resp [2];
    logic [31:0] rdat [2];
    logic        err  [2];
    logic [15:0] ec   [2];
    logic        bsy  [2];

    int checks;
    int failures;

    byte unsigned mb   [2][1024];
    logic [15:0]  m_ec [2];
    logic [31:0]  m_rd [2];

    param_mem_responder #(.LATENCY(2)) u_l2 (
        .clk(clk), .rst_n(rst_n), .mem_read(rd[0]), .mem_write(wr[0]),
        .mem_byte_enable(be[0]), .mem_address(ad[0]), .mem_wdata(wd[0]),
        .halt(hl[0]), .mem_resp(resp[0]), .mem_rdata(rdat[0]),
        .mem_error(err[0]), .errcode(ec[0]), .busy(bsy[0])
    );

    param_mem_responder #(.LATENCY(1)) u_l1 (
        .clk(clk), .rst_n(rst_n), .mem_read(rd[1]), .mem_write(wr[1]),
        .mem_byte_enable(be[1]), .mem_address(ad[1]), .mem_wdata(wd[1]),
        .halt(hl[1]), .mem_resp(resp[1]), .mem_rdata(rdat[1]),
        .mem_error(err[1]), .errcode(ec[1]), .busy(bsy[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            for (int a = 0; a < 1024; a += 4) begin
                mb[i][a]   = 8'h13;
                mb[i][a+1] = 8'h00;
                mb[i][a+2] = 8'h00;
                mb[i][a+3] = 8'h00;
            end
            m_ec[i] = 16'h0;
            m_rd[i] = 32'h0;
        end
    endtask

    function automatic logic [31:0] model_word(input int i, input int a);
        return {mb[i][a+3], mb[i][a+2], mb[i][a+1], mb[i][a]};
    endfunction

    // One request on instance i, issued right after a negedge with the DUT idle.
    task automatic do_req(input int i, input bit r, input bit w, input logic [3:0] bev,
                          input logic [31:0] a, input logic [31:0] d, input bit drop);
        int          lat;
        logic [15:0] bits;
        bit          e;
        lat  = (i == 0) ? 2 : 1;
        bits = 16'h0;
        if (r && w)          bits[0] = 1'b1;
        if (a[1:0] != 2'b00) bits[1] = 1'b1;
        if (a >= 32'd1024)   bits[2] = 1'b1;
        if (w && bev == 4'h0) bits[4] = 1'b1;
        e = |bits;
        if (drop && lat > 1) bits[3] = 1'b1;
        rd[i] = r; wr[i] = w; be[i] = bev; ad[i] = a; wd[i] = d;
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            if (k < lat) begin
                check($sformatf("wait_resp%0d", i), resp[i], 1'b0);
                check($sformatf("wait_busy%0d", i), bsy[i], 1'b1);
                if (drop) begin
                    rd[i] = 1'b0; wr[i] = 1'b0;
                end
            end
        end
        m_ec[i] |= bits;
        if (e) m_rd[i] = 32'h0;
        else if (r) m_rd[i] = model_word(i, int'(a));
        check($sformatf("resp%0d", i), resp[i], 1'b1);
        check($sformatf("error%0d", i), err[i], e);
        check($sformatf("rdata%0d", i), rdat[i], m_rd[i]);
        check($sformatf("errcode%0d", i), ec[i], m_ec[i]);
        check($sformatf("busy_resp%0d", i), bsy[i], 1'b1);
        if (!e && w) begin
            for (int b = 0; b < 4; b++) begin
                if (bev[b]) mb[i][int'(a) + b] = d[b*8 +: 8];
            end
        end
        rd[i] = 1'b0; wr[i] = 1'b0;
        @(negedge clk);
        check($sformatf("idle_resp%0d", i), resp[i], 1'b0);
        check($sformatf("idle_busy%0d", i), bsy[i], 1'b0);
    endtask

    initial begin
        logic [31:0] ra;
        int          inst;
        bit          rr, ww, dr;
        checks = 0;
        failures = 0;
        for (int i = 0; i < 2; i++) begin
            rd[i] = 1'b0; wr[i] = 1'b0; hl[i] = 1'b0;
            be[i] = 4'h0; ad[i] = 32'h0; wd[i] = 32'h0;
        end
        rst_n = 1'b0;
        model_reset();
        #2;
        check("rst_resp", resp[0], 1'b0);
        check("rst_rdata", rdat[0], 32'h0);
        check("rst_errcode", ec[0], 16'h0);
        check("rst_busy", bsy[0], 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic read, byte-enabled write and readback.
        do_req(0, 1, 0, 4'hF, 32'h10, 32'h0, 0);
        check("init_word", rdat[0], 32'h00000013);
        do_req(0, 0, 1, 4'b0101, 32'h20, 32'hDEADBEEF, 0);
        do_req(0, 1, 0, 4'hF, 32'h20, 32'h0, 0);
        check("be_merge", m_rd[0], 32'h00AD00EF);

        // LATENCY=1 read held continuously: response every second cycle.
        rd[1] = 1'b1; ad[1] = 32'h10;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            check($sformatf("b2b_resp_k%0d", k), resp[1], (k % 2) == 1);
            if (k % 2 == 1) check("b2b_rdata", rdat[1], 32'h00000013);
        end
        rd[1] = 1'b0;
        m_rd[1] = 32'h00000013;
        @(negedge clk);
        check("b2b_idle", resp[1], 1'b0);

        // Error cases.
        do_req(0, 1, 0, 4'hF, 32'h22, 32'h0, 0);
        check("misalign_ec", ec[0], 16'h0002);
        do_req(0, 1, 1, 4'hF, 32'h40, 32'h12345678, 0);
        check("rw_ec", ec[0], 16'h0003);
        do_req(0, 1, 0, 4'hF, 32'h400, 32'h0, 0);
        do_req(0, 0, 1, 4'h0, 32'h20, 32'hFFFFFFFF, 0);
        do_req(0, 1, 0, 4'hF, 32'h20, 32'h0, 0);
        check("be0_unchanged", rdat[0], 32'h00AD00EF);
        do_req(0, 1, 0, 4'hF, 32'h24, 32'h0, 1);
        check("drop_ec", ec[0], 16'h001F);

        // halt during WAIT: in-flight read finishes, the next one is held off.
        rd[0] = 1'b1; ad[0] = 32'h20;
        @(negedge clk);
        check("halt_busy", bsy[0], 1'b1);
        hl[0] = 1'b1;
        @(negedge clk);
        m_rd[0] = model_word(0, 32'h20);
        check("halt_resp", resp[0], 1'b1);
        check("halt_rdata", rdat[0], m_rd[0]);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("halt_held_resp", resp[0], 1'b0);
            check("halt_held_busy", bsy[0], 1'b0);
        end
        hl[0] = 1'b0;
        @(negedge clk);
        check("unhalt_busy", bsy[0], 1'b1);
        check("unhalt_resp", resp[0], 1'b0);
        @(negedge clk);
        check("unhalt_resp2", resp[0], 1'b1);
        check("unhalt_rdata", rdat[0], m_rd[0]);
        rd[0] = 1'b0;
        @(negedge clk);

        // Reset pulsed while a read is in WAIT.
        rd[0] = 1'b1; ad[0] = 32'h20;
        @(negedge clk);
        rst_n = 1'b0; rd[0] = 1'b0;
        #1;
        check("midrst_resp", resp[0], 1'b0);
        check("midrst_busy", bsy[0], 1'b0);
        check("midrst_ec", ec[0], 16'h0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("postrst_resp", resp[0], 1'b0);
            check("postrst_busy", bsy[0], 1'b0);
        end
        do_req(0, 1, 0, 4'hF, 32'h20, 32'h0, 0);
        check("postrst_word", rdat[0], 32'h00000013);

        // Request on the very first cycle after reset release.
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        do_req(1, 1, 0, 4'hF, 32'h8, 32'h0, 0);

        // Randomized traffic against the model.
        for (int n = 0; n < 80; n++) begin
            inst = int'($urandom_range(0, 1));
            ra = ($urandom_range(0, 9) == 0) ? 32'($urandom_range(0, 2047))
                                            : 32'($urandom_range(0, 31)) * 4;
            rr = $urandom_range(0, 1) == 1;
            ww = !rr;
            if ($urandom_range(0, 15) == 0) begin
                rr = 1'b1; ww = 1'b1;
            end
            dr = (inst == 0) && ($urandom_range(0, 19) == 0);
            do_req(inst, rr, ww, 4'($urandom_range(0, 15)), ra, $urandom, dr);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/param_mem_responder.md
PARAM_MEM_RESPONDER -- requirements
Module: param_mem_responder

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- DATA_W, 32, data width in bits; multiple of 8, at least 8.
- ADDR_W, 32, byte address width.
- DEPTH, 256, storage words; power of two.
- LATENCY, 2, cycles from request to response; at least 1.
- INIT_WORD, 32'h00000013, reset contents of every word; truncated or zero-extended to DATA_W.
REQ-002 Ports, one per line: name, direction, width, meaning.
- clk, in, 1, the single clock; all state updates on its rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- mem_read, in, 1, read request; held by the requester until mem_resp is seen.
- mem_write, in, 1, write request; held by the requester until mem_resp is seen.
- mem_byte_enable, in, DATA_W/8, per-byte write enable.
- mem_address, in, ADDR_W, byte address.
- mem_wdata, in, DATA_W, write data.
- halt, in, 1, when 1, no new request is accepted.
- mem_resp, out, 1, one-cycle completion pulse.
- mem_rdata, out, DATA_W, read data; valid only while mem_resp=1.
- mem_error, out, 1, asserted with mem_resp when the completing request was erroneous.
- errcode, out, 16, sticky error flags.
- busy, out, 1, a request is in flight.

Function
REQ-003 Definitions:
- OFF = log2(DATA_W/8).
- Word index = mem_address[OFF+log2(DEPTH)-1:OFF].
REQ-004 FSM states are IDLE, WAIT and RESP. All outputs are registered.
REQ-005 IDLE accepts a request in a cycle where halt=0 and (mem_read or mem_write) is 1. The rising edge ending that cycle latches address, wdata, byte_enable and operation, then moves to WAIT, or to RESP when LATENCY=1.
REQ-006 WAIT holds a down-counter loaded with LATENCY-1. The counter decrements each cycle, and the FSM enters RESP when the counter reaches 1. For a request visible in cycle c, mem_resp=1 exactly in cycle c+LATENCY.
REQ-007 RESP:
- mem_resp=1 for exactly one cycle.
- For a read, mem_rdata = the stored word.
- For a write, each byte i with byte_enable[i]=1 is updated at the edge ending RESP; other bytes are unchanged.
- The next state is IDLE unconditionally.
REQ-008 A request still asserted in the IDLE cycle after RESP is treated as a new request, so back-to-back requests run with one IDLE cycle between them.
REQ-009 When mem_resp=0, mem_rdata holds its previous value. mem_rdata is not updated on writes.
REQ-010 Errors are detected at acceptance. They are OR-ed into errcode, which is sticky until reset:
- bit0: mem_read and mem_write both 1.
- bit1: address[OFF-1:0] nonzero (only when OFF>0).
- bit2: address at or above DEPTH*(DATA_W/8).
- bit3: mem_read and mem_write both 0 during WAIT (request dropped).
- bit4: write with byte_enable all zero.
- bits 15:5: 0.
REQ-011 An erroneous request still completes with normal timing:
- mem_resp=1 and mem_error=1 in the same cycle.
- No storage update.
- mem_rdata=0.
REQ-012 Bit3 is flagged in errcode only. The in-flight request still completes normally and mem_error is not asserted for it.
REQ-013 halt=1 blocks only acceptance in IDLE. In-flight requests finish.
REQ-014 busy=1 in WAIT and RESP, and 0 in IDLE.
REQ-015 Address bits above the index are ignored once the range check passes.

Reset
REQ-016 While rst_n=0, asynchronously and independent of clk:
- State goes to IDLE.
- mem_resp, mem_error and busy go to 0.
- mem_rdata goes to 0.
- errcode goes to 0.
- The counter goes to 0.
- Every storage word goes to INIT_WORD.
REQ-017 If reset is asserted mid-request, the request is aborted: no write occurs and no mem_resp is issued after rst_n returns to 1. The first request is accepted in the first cycle after deassertion.

Verification
REQ-018 The bench SHALL cover at least:
- Reset, LATENCY=2: read address 0x10 in cycle c -> mem_resp=1 only in cycle c+2, mem_rdata=0x00000013, mem_error=0.
- Write 0xDEADBEEF, byte_enable=4'b0101, to 0x20; then read 0x20 -> mem_rdata=0x00AD00EF.
- LATENCY=1: back-to-back reads held continuously -> mem_resp pulses every 2nd cycle.
- Read of 0x22 -> mem_resp=1, mem_error=1, mem_rdata=0, errcode=0x0002. A following read and write together -> errcode=0x0003.
- Read of 0x400 with DEPTH=256 -> mem_error=1, errcode bit2 set. Write with byte_enable=0 -> storage unchanged, bit4 set.
- halt=1 while a read is in WAIT -> that read completes. A second read is held off until halt=0. rst_n pulsed low in WAIT -> no mem_resp, and a previously written word reads back as 0x00000013.
